conv3x3_multi: RTL and testbench
================================

// Module: conv3x3_multi
// PURPOSE
//  Parametrised 3x3 gradient/edge filter for the streaming video effects chain. It takes a packed 3x3 neighbourhood
//  per beat, applies the kernel chosen by a per-frame mode (Scharr-X, Scharr-Y, |Gx|+|Gy|, passthrough), then clamps
//  and rescales each channel. Valid/ready handshake with backpressure; counts saturated pixels per frame for tuning.
// PARAMETERS
//  CH_BITS    4   bits per colour channel
//  NUM_CH     3   channels per pixel; channel NUM_CH-1 at pixel MSB (red)
//  OUT_SHIFT  4   clamp ceiling is 2^(CH_BITS+OUT_SHIFT)-1; output = clamped >> OUT_SHIFT
//  ACC_BITS   16  signed accumulator width; must be >= CH_BITS+7
//  CNT_BITS   20  saturation counter width
// PORTS
//  clk            in   1                   system clock
//  reset          in   1                   synchronous, active-low reset
//  in_valid       in   1                   window beat valid
//  in_ready       out  1                   block accepts beat this cycle
//  in_sof         in   1                   beat is first pixel of frame
//  mode           in   2                   0 GX, 1 GY, 2 MAG, 3 PASS; sampled only on accepted in_sof beat
//  color_data     in   9*NUM_CH*CH_BITS    window, 9 pixels MSB->LSB: centre,L,R,U,D,UL,UR,DL,DR
//  out_valid      out  1                   filtered pixel valid
//  out_ready      in   1                   downstream accepts
//  out_sof        out  1                   aligned with the filtered pixel of the in_sof beat
//  filter_rgb_out out  NUM_CH*CH_BITS      filtered pixel
//  sat_count      out  CNT_BITS            saturated-pixel count of last completed frame
// BEHAVIOUR
//  - Clock clk; synchronous, active-low reset. While reset=0 at a clk edge: all stage valids, out_valid, out_sof,
//    filter_rgb_out, sat_count, running counter and the mode register (GX) clear to 0.
//  - 3-stage pipeline: S1 registers window+sof+mode; S2 computes signed sums per channel; S3 clamps/shifts to outputs.
//  - advance = !out_valid | out_ready; in_ready = advance (combinational). On advance all stages shift;
//    otherwise every stage holds. Unstalled latency: accepted beat at cycle N -> out_valid at N+3.
//  - Beat transfers in when in_valid&in_ready and out when out_valid&out_ready. No beat is dropped or duplicated under any
//    out_ready pattern. Bubbles propagate as valid=0.
//  - Mode: updated only when an accepted beat has in_sof=1; that beat and all later ones use the new mode. Mode
//    travels with data through S1, so in-flight pixels keep their frame's mode.
//  - Kernels (Scharr): GX = -3UL+3UR-10L+10R-3DL+3DR; GY = -3UL-10U-3UR+3DL+10D+3DR;
//    MAG = |GX|+|GY|; PASS = centre << OUT_SHIFT. Channels use unsigned operands, ACC_BITS signed arithmetic.
//  - Clamp: v<0 -> 0; v>MAX -> MAX (MAX=2^(CH_BITS+OUT_SHIFT)-1); output channel = clamp[CH_BITS+OUT_SHIFT-1:OUT_SHIFT].
//  - Saturation flag for a pixel = any channel with v>MAX (negative clamp is not saturation).
//  - Counter: counts on output transfer. On a transfer with out_sof=1: sat_count <= running count (or that value
//    left unchanged if no prior frame), running <= flag of this beat. Otherwise running += flag, saturating at
//    all-ones (no wrap). sat_count is stable between out_sof transfers.
//  - Reset mid-frame: pipeline contents discarded, no out_valid until new beats enter; next frame starts clean.
//  - Simultaneous in and out transfer with full pipeline is legal: throughput 1 beat/cycle when out_ready=1.
// TESTING
//  1 Reset: reset=0 for 2 clks with in_valid=1 -> out_valid=0, filter_rgb_out=0, sat_count=0, in_ready=1 after release.
//  2 GX, defaults: red R-column=F, green R-column=2, blue L-column=F, rest 0, in_sof=1 mode=0 -> 12'hF20 exactly 3 clks later.
//  3 Same window, new frame mode=1 (GY) -> 12'h000; mode=2 (MAG) -> 12'hF2F; mode=3, centre 12'hA5C -> 12'hA5C.
//  4 Mode changed on non-sof beats mid-frame -> outputs keep frame's mode until next accepted in_sof.
//  5 Stream 64 beats, out_ready random 50% -> output sequence equals golden model, no drop/dup, in_ready=0 only when stalled.
//  6 MAG, red UR,R,DR,D,DL=F (GX=GY=195, sum 390) on 10 of 40 pixels, then in_sof -> red=F, sat_count=10 after sof.

Source files
------------

// File: rtl/conv3x3_multi.sv
// Streaming 3x3 Scharr gradient / magnitude / passthrough filter with per-frame mode
// and a per-frame saturated-pixel counter. Three-stage pipeline with valid/ready backpressure.

module conv3x3_lane #(
  parameter int CH_BITS   = 4,
  parameter int OUT_SHIFT = 4,
  parameter int ACC_BITS  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        advance,
  input  logic [8:0][CH_BITS-1:0]     win,
  input  logic [1:0]                  mode,
  output logic [CH_BITS-1:0]          chan,
  output logic                        sat
);
  typedef enum logic [1:0] {GX, GY, MAG, PASS} mode_e;

  localparam int CW = CH_BITS + OUT_SHIFT;
  localparam int C = 8, L = 7, R = 6, U = 5, D = 4, UL = 3, UR = 2, DL = 1, DR = 0;
  localparam logic signed [ACC_BITS-1:0] K3   = ACC_BITS'(3);
  localparam logic signed [ACC_BITS-1:0] K10  = ACC_BITS'(10);
  localparam logic signed [ACC_BITS-1:0] MAXV = ACC_BITS'((1 << CW) - 1);

  logic signed [ACC_BITS-1:0] px [9];
  logic signed [ACC_BITS-1:0] gx, gy, ax, ay, acc, acc_q;
  logic [CH_BITS-1:0]         chan_d;

  always_comb begin
    for (int k = 0; k < 9; k++) px[k] = $signed({{(ACC_BITS-CH_BITS){1'b0}}, win[k]});
    gx  = K3 * (px[UR] - px[UL]) + K10 * (px[R] - px[L]) + K3 * (px[DR] - px[DL]);
    gy  = K3 * (px[DL] - px[UL]) + K10 * (px[D] - px[U]) + K3 * (px[DR] - px[UR]);
    ax  = gx[ACC_BITS-1] ? -gx : gx;
    ay  = gy[ACC_BITS-1] ? -gy : gy;
    acc = gx;
    case (mode_e'(mode))
      GX:   acc = gx;
      GY:   acc = gy;
      MAG:  acc = ax + ay;
      PASS: acc = px[C] <<< OUT_SHIFT;
      default: acc = gx;
    endcase
  end

  // Clamp to [0, MAX] and keep the top CH_BITS of the CW-bit clamped value.
  always_comb begin
    chan_d = acc_q[CW-1:OUT_SHIFT];
    if (acc_q[ACC_BITS-1])  chan_d = '0;
    else if (acc_q > MAXV)  chan_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      chan  <= '0;
      sat   <= 1'b0;
    end else if (advance) begin
      acc_q <= acc;
      chan  <= chan_d;
      sat   <= acc_q > MAXV;
    end
  end
endmodule

module conv3x3_multi #(
  parameter int CH_BITS   = 4,
  parameter int NUM_CH    = 3,
  parameter int OUT_SHIFT = 4,
  parameter int ACC_BITS  = 16,
  parameter int CNT_BITS  = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [1:0]                    mode,
  input  logic [9*NUM_CH*CH_BITS-1:0]   color_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic [NUM_CH*CH_BITS-1:0]     filter_rgb_out,
  output logic [CNT_BITS-1:0]           sat_count
);
  localparam int PW     = NUM_CH * CH_BITS;
  localparam int STAGES = 3;

  logic [STAGES:1]                      vld_pipe;
  logic                                 advance, accept, xfer;
  logic [1:0]                           mode_q, mode_eff, s1_mode;
  logic [9*PW-1:0]                      s1_win;
  logic                                 s1_sof, s2_sof;
  logic [NUM_CH-1:0][8:0][CH_BITS-1:0]  lane_win;
  logic [NUM_CH-1:0][CH_BITS-1:0]       lane_chan;
  logic [NUM_CH-1:0]                    lane_sat;
  logic [CNT_BITS-1:0]                  run_cnt;
  logic                                 have_frame;

  assign advance        = !vld_pipe[STAGES] | out_ready;
  assign in_ready       = advance;
  assign accept         = in_valid & advance;
  assign out_valid      = vld_pipe[STAGES];
  assign xfer           = out_valid & out_ready;
  assign mode_eff       = in_sof ? mode : mode_q;
  assign filter_rgb_out = lane_chan;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      mode_q   <= 2'd0;
      s1_win   <= '0;
      s1_sof   <= 1'b0;
      s1_mode  <= 2'd0;
      s2_sof   <= 1'b0;
      out_sof  <= 1'b0;
    end else begin
      if (accept && in_sof) mode_q <= mode;
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
        s1_win   <= color_data;
        s1_sof   <= in_sof & in_valid;
        s1_mode  <= mode_eff;
        s2_sof   <= s1_sof;
        out_sof  <= s2_sof;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    for (genvar k = 0; k < 9; k++) begin : g_tap
      assign lane_win[g][k] = s1_win[k*PW + g*CH_BITS +: CH_BITS];
    end
    conv3x3_lane #(
      .CH_BITS(CH_BITS), .OUT_SHIFT(OUT_SHIFT), .ACC_BITS(ACC_BITS)
    ) u_lane (
      .clk(clk), .reset(reset), .advance(advance),
      .win(lane_win[g]), .mode(s1_mode),
      .chan(lane_chan[g]), .sat(lane_sat[g])
    );
  end

  // The first sof after reset has no completed frame behind it, so sat_count is left alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_count  <= '0;
      run_cnt    <= '0;
      have_frame <= 1'b0;
    end else if (xfer) begin
      if (out_sof) begin
        if (have_frame) sat_count <= run_cnt;
        run_cnt    <= CNT_BITS'(|lane_sat);
        have_frame <= 1'b1;
      end else if (run_cnt != '1) begin
        run_cnt <= run_cnt + CNT_BITS'(|lane_sat);
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_multi.sv
// Directed bench for conv3x3_multi: latency, per-frame mode, backpressure streaming, reset and sat counter.

module tb_conv3x3_multi;
  localparam int CNT_BITS = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [107:0]  color_data = '0;
  logic          in_ready, out_valid, out_sof;
  logic [11:0]   filter_rgb_out;
  logic [CNT_BITS-1:0] sat_count;

  int checks = 0, failures = 0;
  logic [13:0] exp_q[$];
  logic [CNT_BITS-1:0] m_sat = '0, m_run = '0;
  logic m_have = 1'b0, rnd_rdy = 1'b0, acc_seen, ov_seen;

  conv3x3_multi #(.CH_BITS(4), .NUM_CH(3), .OUT_SHIFT(4), .ACC_BITS(16), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .mode(mode), .color_data(color_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .filter_rgb_out(filter_rgb_out), .sat_count(sat_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [107:0] mkwin(input logic [11:0] c, l, r, u, d, ul, ur, dl, dr);
    return {c, l, r, u, d, ul, ur, dl, dr};
  endfunction

  // Returns {sat, pixel}; pixel index k: 0 DR,1 DL,2 UR,3 UL,4 D,5 U,6 R,7 L,8 centre.
  function automatic logic [12:0] model(input logic [107:0] w, input logic [1:0] m);
    int p[9];
    int gx, gy, v;
    logic [11:0] pix = '0;
    logic sat = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 9; k++) p[k] = int'(w[k*12 + ch*4 +: 4]);
      gx = -3*p[3] + 3*p[2] - 10*p[7] + 10*p[6] - 3*p[1] + 3*p[0];
      gy = -3*p[3] - 10*p[5] - 3*p[2] + 3*p[1] + 10*p[4] + 3*p[0];
      case (m)
        2'd0: v = gx;
        2'd1: v = gy;
        2'd2: v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        default: v = p[8] * 16;
      endcase
      if (v > 255) begin sat = 1'b1; v = 255; end
      else if (v < 0) v = 0;
      pix[ch*4 +: 4] = 4'(v >> 4);
    end
    return {sat, pix};
  endfunction

  // One clock: observe at negedge (transfers happen on the next posedge), drive #1 after posedge.
  task automatic tick();
    logic [13:0] it;
    @(negedge clk);
    ov_seen  = out_valid;
    acc_seen = in_valid && in_ready;
    if (reset) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("sat_count", sat_count, m_sat);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_output", out_valid, 0);
        else begin
          it = exp_q.pop_front();
          chk("out_sof", out_sof, it[12]);
          chk("out_pix", filter_rgb_out, it[11:0]);
          if (it[12]) begin
            if (m_have) m_sat = m_run;
            m_run  = CNT_BITS'(it[13]);
            m_have = 1'b1;
          end else if (m_run != '1) m_run = m_run + CNT_BITS'(it[13]);
        end
      end
    end
    @(posedge clk);
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input logic sof, input logic [1:0] md, input logic [107:0] w,
                      input logic [11:0] e_pix, input logic e_sat);
    int n = 0;
    in_valid = 1'b1; in_sof = sof; mode = md; color_data = w;
    do begin tick(); n++; end while (!acc_seen && n < 200);
    if (!acc_seen) chk("accept_timeout", in_ready, 1);
    else exp_q.push_back({e_sat, sof, e_pix});
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin tick(); n++; end
    chk("drain_empty", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; in_valid = 1'b1; in_sof = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    exp_q.delete();
    m_sat = '0; m_run = '0; m_have = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_pix", filter_rgb_out, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) begin tick(); chk("rst_no_valid", ov_seen, 0); end
  endtask

  initial begin
    logic [107:0] w2, w3, ws, wz, w;
    logic [12:0] e;
    logic [1:0] fm, md;
    logic sof;
    w2 = mkwin(12'h000, 12'h00F, 12'hF20, 12'h000, 12'h000, 12'h00F, 12'hF20, 12'h00F, 12'hF20);
    w3 = w2 | mkwin(12'hA5C, 0, 0, 0, 0, 0, 0, 0, 0);
    ws = mkwin(12'h000, 12'h000, 12'hF00, 12'h000, 12'hF00, 12'h000, 12'hF00, 12'hF00, 12'hF00);
    wz = '0;
    color_data = w2;

    // Reset with in_valid high
    do_reset(2);

    // GX default frame, 3-cycle latency
    send(1, 2'd0, w2, 12'hF20, 0);
    tick(); chk("lat_c1", ov_seen, 0);
    tick(); chk("lat_c2", ov_seen, 0);
    tick(); chk("lat_c3", ov_seen, 1);

    // New frames in each mode
    send(1, 2'd1, w2, 12'h000, 0);
    send(1, 2'd2, w2, 12'hF2F, 0);
    send(1, 2'd3, w3, 12'hA5C, 0);
    drain();

    // Mode changes on non-sof beats are ignored
    send(1, 2'd0, w2, 12'hF20, 0);
    send(0, 2'd1, w2, 12'hF20, 0);
    send(0, 2'd3, w2, 12'hF20, 0);
    send(1, 2'd1, w2, 12'h000, 0);
    send(0, 2'd2, w2, 12'h000, 0);
    drain();

    // Random backpressure stream against the model
    rnd_rdy = 1'b1;
    fm = 2'd0;
    for (int i = 0; i < 64; i++) begin
      sof = (i % 16 == 0);
      md  = 2'($urandom_range(0, 3));
      if (sof) fm = md;
      for (int k = 0; k < 9; k++) w[k*12 +: 12] = 12'($urandom);
      e = model(w, fm);
      send(sof, md, w, e[11:0], e[12]);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (2) tick();

    // Reset mid-frame with beats in flight; mode register returns to GX
    send(1, 2'd2, w2, 12'hF2F, 0);
    send(0, 2'd2, w2, 12'hF2F, 0);
    do_reset(1);
    send(0, 2'd3, w2, 12'hF20, 0);
    drain();

    // Saturation counting: 10 of 40 pixels saturate in MAG
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) send(i == 0, 2'd2, ws, 12'hF00, 1);
      else            send(i == 0, 2'd2, wz, 12'h000, 0);
    end
    send(1, 2'd2, wz, 12'h000, 0);
    drain();
    @(negedge clk);
    chk("sat_count_10", sat_count, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
